// File: rtl/exec_pkg.sv
// Shared types and constants for the exec_unit datapath.
// The iterative multiplier is built only when EXEC_MUL_EN is defined.
package exec_pkg;

   localparam int unsigned EXEC_WIDTH = 16;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_AND  = 3'b001,
      OP_NOT  = 3'b010,
      OP_PASS = 3'b011,
      OP_MUL  = 3'b100,
      OP_SHL  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL,
      S_DONE
   } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier, WIDTH iterations per product (low WIDTH bits).
// Present only when EXEC_MUL_EN is defined; otherwise no multiplier exists.
`ifdef EXEC_MUL_EN
module mul_iter
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH = EXEC_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] product,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [CW-1:0]    cnt_q;
   logic             done_q;

   // One multiplier bit per cycle; done pulses the cycle after the last add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= CW'(WIDTH);
         end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
               acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            done_q   <= (cnt_q == CW'(1));
         end
      end
   end

   assign product = acc_q;
   assign done    = done_q;

endmodule
`endif

// File: rtl/exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU ops plus optional iterative MUL.
// Define EXEC_MUL_EN to build the MUL state and the mul_iter multiplier.
module exec_unit
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH = EXEC_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] SR1_In,
   input  logic [WIDTH-1:0] SR2_In,
   input  logic [4:0]       Imm5,
   input  logic             SR2MUX,
   input  logic             LD_CC,
   output logic [WIDTH-1:0] Result,
   output logic             Busy,
   output logic             Done,
   output logic             N,
   output logic             Z,
   output logic             P
);

   state_e           state_q;
   state_e           state_n;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             ld_cc_q;
   logic [WIDTH-1:0] result_q;
   logic             busy_q;
   logic             done_q;
   logic             n_q;
   logic             z_q;
   logic             p_q;

   logic [WIDTH-1:0] b_sel_c;
   logic [WIDTH-1:0] alu_c;
   logic [WIDTH-1:0] result_n;
   logic             accept_c;
   logic             load_c;
   logic             mul_op_c;

   assign b_sel_c = SR2MUX ? {{(WIDTH-5){Imm5[4]}}, Imm5} : SR2_In;

`ifdef EXEC_MUL_EN
   logic [WIDTH-1:0] mul_product;
   logic             mul_done;

   assign mul_op_c = (Op == OP_MUL);

   // Multiplier loads straight from the operand inputs in the accept cycle.
   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (Clk),
      .rst     (Reset),
      .start   (accept_c && mul_op_c),
      .a       (SR1_In),
      .b       (b_sel_c),
      .product (mul_product),
      .done    (mul_done)
   );
`else
   assign mul_op_c = 1'b0;
`endif

   // Single-cycle operations on the captured operands.
   always_comb begin
      alu_c = '0;
      case (op_q)
         OP_ADD:  alu_c = a_q + b_q;
         OP_AND:  alu_c = a_q & b_q;
         OP_NOT:  alu_c = ~a_q;
         OP_PASS: alu_c = a_q;
         OP_SHL:  alu_c = a_q << b_q[3:0];
         default: alu_c = '0;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_comb begin
      state_n  = state_q;
      accept_c = 1'b0;
      load_c   = 1'b0;
      result_n = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_n = S_IDLE;
            if (Start) begin
               accept_c = 1'b1;
               state_n  = mul_op_c ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: begin
            load_c   = 1'b1;
            result_n = alu_c;
            state_n  = S_DONE;
         end
`ifdef EXEC_MUL_EN
         S_MUL: begin
            if (mul_done) begin
               load_c   = 1'b1;
               result_n = mul_product;
               state_n  = S_DONE;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   // Flags are registered from the next state so they line up with it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ld_cc_q  <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         n_q      <= 1'b0;
         z_q      <= 1'b1;
         p_q      <= 1'b0;
      end else begin
         busy_q <= (state_n == S_EXEC) || (state_n == S_MUL);
         done_q <= (state_n == S_DONE);
         if (accept_c) begin
            op_q    <= Op;
            a_q     <= SR1_In;
            b_q     <= b_sel_c;
            ld_cc_q <= LD_CC;
         end
         if (load_c) begin
            result_q <= result_n;
            if (ld_cc_q) begin
               n_q <= result_n[WIDTH-1];
               z_q <= (result_n == '0);
               p_q <= !result_n[WIDTH-1] && (result_n != '0);
            end
         end
      end
   end

   assign Result = result_q;
   assign Busy   = busy_q;
   assign Done   = done_q;
   assign N      = n_q;
   assign Z      = z_q;
   assign P      = p_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit against a behavioural operation model.
// Honours EXEC_MUL_EN the same way as the design.
module tb_exec_unit;

`ifdef EXEC_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [2:0]  Op;
   logic [15:0] SR1_In;
   logic [15:0] SR2_In;
   logic [4:0]  Imm5;
   logic        SR2MUX;
   logic        LD_CC;
   logic [15:0] Result;
   logic        Busy;
   logic        Done;
   logic        N;
   logic        Z;
   logic        P;

   int compared   = 0;
   int mismatched = 0;

   logic [15:0] m_result;
   logic [2:0]  m_cc;
   logic [15:0] p_res;
   logic [2:0]  p_cc;
   int          p_lat;

   exec_unit #(.WIDTH(16)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .Op     (Op),
      .SR1_In (SR1_In),
      .SR2_In (SR2_In),
      .Imm5   (Imm5),
      .SR2MUX (SR2MUX),
      .LD_CC  (LD_CC),
      .Result (Result),
      .Busy   (Busy),
      .Done   (Done),
      .N      (N),
      .Z      (Z),
      .P      (P)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: what the operation produces and when, from the opcode table.
   task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sr2,
                        input logic [4:0] imm, input logic sr2mux, input logic ldcc);
      logic [15:0] b;
      logic [31:0] prod;
      b = sr2mux ? 16'($signed(imm)) : sr2;
      prod = 32'(a) * 32'(b);
      case (op)
         3'd0:    p_res = a + b;
         3'd1:    p_res = a & b;
         3'd2:    p_res = ~a;
         3'd3:    p_res = a;
         3'd4:    p_res = MUL_ON ? prod[15:0] : 16'h0000;
         3'd5:    p_res = a << (b % 16);
         default: p_res = 16'h0000;
      endcase
      p_lat = (op == 3'd4 && MUL_ON) ? 18 : 2;
      if (ldcc) p_cc = p_res[15] ? 3'b100 : ((p_res == 16'h0) ? 3'b010 : 3'b001);
      else      p_cc = m_cc;
      Op = op; SR1_In = a; SR2_In = sr2; Imm5 = imm; SR2MUX = sr2mux; LD_CC = ldcc;
      Start = 1'b1;
   endtask

   // Walk the op to its Done cycle; optionally pulse Start while busy.
   task automatic complete(input bit poke);
      for (int c = 1; c <= p_lat; c++) begin
         @(posedge Clk); #1;
         if (c == 1) begin
            Start  = poke;
            Op     = 3'($urandom);
            SR1_In = 16'($urandom);
            SR2_In = 16'($urandom);
            Imm5   = 5'($urandom);
            SR2MUX = 1'($urandom);
            LD_CC  = 1'($urandom);
         end else begin
            Start = 1'b0;
         end
         if (c < p_lat) begin
            check("busy_high", 32'(Busy), 32'd1);
            check("done_low", 32'(Done), 32'd0);
            check("result_hold", 32'(Result), 32'(m_result));
            check("cc_hold", 32'({N, Z, P}), 32'(m_cc));
         end else begin
            m_result = p_res;
            m_cc     = p_cc;
            check("done_pulse", 32'(Done), 32'd1);
            check("busy_low", 32'(Busy), 32'd0);
            check("result", 32'(Result), 32'(m_result));
            check("cc", 32'({N, Z, P}), 32'(m_cc));
         end
      end
   endtask

   task automatic idle_check();
      @(posedge Clk); #1;
      check("idle_done", 32'(Done), 32'd0);
      check("idle_busy", 32'(Busy), 32'd0);
      check("idle_result", 32'(Result), 32'(m_result));
      check("idle_cc", 32'({N, Z, P}), 32'(m_cc));
   endtask

   initial begin
      int rst_wait;
      logic [2:0] rop;
      bit b2b;
      Reset = 1'b1; Start = 1'b0; Op = '0; SR1_In = '0; SR2_In = '0;
      Imm5 = '0; SR2MUX = 1'b0; LD_CC = 1'b0;
      m_result = 16'h0000; m_cc = 3'b010;
      #1;
      check("rst_result", 32'(Result), 32'h0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_cc", 32'({N, Z, P}), 32'b010);
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(posedge Clk); #1;

      // ADD with sign-extended +1 crossing into negative
      issue(3'd0, 16'h7FFF, 16'h0000, 5'h01, 1'b1, 1'b1); complete(1'b0); idle_check();
      // AND from register operand, CC untouched
      issue(3'd1, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0, 1'b0); complete(1'b0); idle_check();
      // MUL with an ignored Start while busy
      issue(3'd4, 16'h0123, 16'h0045, 5'h00, 1'b0, 1'b1); complete(1'b1); idle_check();
      issue(3'd4, 16'h0003, 16'h0005, 5'h00, 1'b0, 1'b1); complete(1'b0); idle_check();
      // Wrap to zero, then back-to-back from the Done cycle
      issue(3'd0, 16'hFFFF, 16'h0000, 5'h01, 1'b1, 1'b1); complete(1'b0);
      issue(3'd3, 16'h1234, 16'h0000, 5'h00, 1'b0, 1'b1); complete(1'b0); idle_check();
      issue(3'd5, 16'h0001, 16'h001F, 5'h00, 1'b0, 1'b1); complete(1'b0); idle_check();
      issue(3'd0, 16'h0005, 16'h0000, 5'h10, 1'b1, 1'b1); complete(1'b1); idle_check();
      issue(3'd2, 16'h00FF, 16'h0000, 5'h00, 1'b0, 1'b1); complete(1'b0); idle_check();
      issue(3'd6, 16'hABCD, 16'h1111, 5'h00, 1'b0, 1'b1); complete(1'b0); idle_check();

      // Reset during an in-flight operation
      rst_wait = MUL_ON ? 8 : 1;
      issue(3'd4, 16'h0123, 16'h0045, 5'h00, 1'b0, 1'b1);
      for (int c = 0; c < rst_wait; c++) begin
         @(posedge Clk); #1;
         Start = 1'b0;
      end
      Reset = 1'b1;
      #1;
      m_result = 16'h0000; m_cc = 3'b010;
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_result", 32'(Result), 32'h0);
      check("abort_cc", 32'({N, Z, P}), 32'b010);
      check("abort_done", 32'(Done), 32'd0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk); #1;
         check("abort_no_done", 32'(Done), 32'd0);
      end

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         issue(rop, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
         complete(1'($urandom));
         b2b = 1'($urandom);
         if (!b2b) idle_check();
      end
      idle_check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the datapath width of operands and result.
REQ-002 SHALL have port Clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request an operation; sampled only when the unit is not busy.
REQ-005 SHALL have port Op  input  3  opcode: 000 ADD, 001 AND, 010 NOT SR1, 011 PASS SR1, 100 MUL, 101 SHL, 110-111 reserved.
REQ-006 SHALL have port SR1_In  input  WIDTH  operand A, driven from the register file SR1 output.
REQ-007 SHALL have port SR2_In  input  WIDTH  register operand B, driven from the register file SR2 output.
REQ-008 SHALL have port Imm5  input  5  immediate operand.
REQ-009 SHALL have port SR2MUX  input  1  operand B select: 1 = sign-extended Imm5, 0 = SR2_In.
REQ-010 SHALL have port LD_CC  input  1  update condition codes on completion; sampled with Start.
REQ-011 SHALL have port Result  output  WIDTH  registered result, destined for the register file Data input.
REQ-012 SHALL have port Busy  output  1  high while an operation is in flight.
REQ-013 SHALL have port Done  output  1  single-cycle pulse when Result is newly valid.
REQ-014 SHALL have ports N, Z, P  output  1 each  condition-code registers.

Function
REQ-015 SHALL run a state machine with states IDLE, EXEC, MUL and DONE.
REQ-016 IDLE + Start SHALL register Op, A, B (B = SR2MUX ? sext(Imm5) : SR2_In) and LD_CC; next state is MUL if Op=100, otherwise EXEC.
REQ-017 EXEC SHALL compute, write Result, and go to DONE: ADD = A+B mod 2^WIDTH; AND = A&B; NOT = ~A; PASS = A; SHL = A << B[3:0]; reserved = 0.
REQ-018 MUL SHALL perform shift-add over exactly WIDTH cycles; Result = low WIDTH bits of A*B (unsigned); then go to DONE.
REQ-019 DONE SHALL assert Done for exactly one cycle; latency from Start is 2 cycles for EXEC ops and WIDTH+2 cycles for MUL.
REQ-020 Start in DONE SHALL be accepted as if the unit were in IDLE, giving back-to-back operation.
REQ-021 Busy SHALL be high in EXEC and MUL, and low in IDLE and DONE.
REQ-022 Start while Busy SHALL be ignored; operands and state are unaffected.
REQ-023 Result SHALL hold its value until the next Done.
REQ-024 When Done and the captured LD_CC are both high, the unit SHALL set N = Result[WIDTH-1], Z = (Result==0), P = otherwise; exactly one of N, Z, P is high at all times.
REQ-025 Operand changes after capture SHALL NOT affect the in-flight result.

Reset
REQ-026 Reset SHALL force state IDLE, Result=0, Busy=0, Done=0, N=0, Z=1, P=0, and clear all operand registers.
REQ-027 Reset asserted mid-MUL SHALL abort the operation with no Done pulse and no condition-code update.

Configuration
REQ-028 With macro EXEC_MUL_EN defined, the unit SHALL include the MUL state and the multiplier.
REQ-029 Without EXEC_MUL_EN, Op=100 SHALL behave as reserved (Result=0, 2-cycle latency), and no multiplier logic is synthesised.

Structure
REQ-030 Package exec_pkg SHALL hold the opcode enum, the state enum and the WIDTH default constant.
REQ-031 The iterative multiplier SHALL be the sub-module mul_iter (inputs start, a, b; outputs product, done), instantiated only under EXEC_MUL_EN.

Verification
REQ-032 ADD with A=0x7FFF, Imm5=0x01, SR2MUX=1, LD_CC=1 -> Result=0x8000 two cycles after Start; N=1, Z=0, P=0.
REQ-033 AND with A=0xF0F0, SR2_In=0x0FF0, SR2MUX=0 -> Result=0x00F0; Done pulses for 1 cycle; Busy high for exactly 1 cycle.
REQ-034 MUL with A=0x0123, B=0x0045 (EXEC_MUL_EN) -> Result=0x4E6F at cycle 18 after Start; Start pulsed mid-MUL is ignored.
REQ-035 ADD with A=0xFFFF, Imm5=0x01, followed by Start in the DONE cycle -> first Result=0x0000 with Z=1; second op completes 2 cycles later.
REQ-036 Reset asserted at cycle 8 of a MUL -> Busy=0, Result=0, Z=1 immediately; no Done pulse.
REQ-037 Without EXEC_MUL_EN, Op=100 with A=3, B=5 -> Result=0x0000 two cycles after Start.
